// File: rtl/load_store_unit.sv
// Load/store unit: RV32I byte/half/word access to a local data memory.
// Fixed-latency request/response handshake with misalignment and range faults.
module load_store_unit #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          rd_q, wr_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q, wdata_q;
  logic          resp_valid_q, fault_q;
  logic [31:0]   load_data_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept, enter_resp, use_in;
  logic          op_rd, op_wr;
  logic [2:0]    op_f3;
  logic [31:0]   op_addr, op_wdata;
  logic [AW-1:0] idx;
  logic [31:0]   rword, wword, ld_d;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic          f3_bad, mis, oob, fault_d, mem_we;

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign load_data  = load_data_q;
  assign fault      = fault_q;

  assign accept = req_valid && req_ready;
  assign enter_resp = (accept && LATENCY == 1) ||
                      (state_q == WAIT && cnt_q == '0);

  // With single-cycle latency the access happens on the accepting edge,
  // so the live inputs stand in for the not-yet-loaded request registers.
  assign use_in   = (state_q == IDLE);
  assign op_rd    = use_in ? mem_read   : rd_q;
  assign op_wr    = use_in ? mem_write  : wr_q;
  assign op_f3    = use_in ? funct3     : f3_q;
  assign op_addr  = use_in ? addr       : addr_q;
  assign op_wdata = use_in ? store_data : wdata_q;

  assign idx   = op_addr[AW+1:2];
  assign rword = mem_q[idx];
  assign rbyte = 8'(rword >> {op_addr[1:0], 3'b000});
  assign rhalf = 16'(rword >> {op_addr[1], 4'b0000});
  assign oob   = |op_addr[31:AW+2];

  always_comb begin
    f3_bad = 1'b0;
    if (op_wr)
      f3_bad = op_f3[2] || (op_f3[1:0] == 2'b11);
    else
      f3_bad = (op_f3 == 3'b011) || (op_f3[2:1] == 2'b11);
    mis = ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
          ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
    fault_d = (op_rd == op_wr) || f3_bad || mis || oob;
  end

  always_comb begin
    ld_d = '0;
    unique case (1'b1)
      op_f3 == 3'b000: ld_d = {{24{rbyte[7]}}, rbyte};
      op_f3 == 3'b001: ld_d = {{16{rhalf[15]}}, rhalf};
      op_f3 == 3'b010: ld_d = rword;
      op_f3 == 3'b100: ld_d = {24'h0, rbyte};
      op_f3 == 3'b101: ld_d = {16'h0, rhalf};
      default:         ld_d = '0;
    endcase
  end

  always_comb begin
    wword = rword;
    unique case (1'b1)
      op_f3 == 3'b000:
        wword[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
      op_f3 == 3'b001:
        wword[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
      op_f3 == 3'b010:
        wword = op_wdata;
      default:
        wword = rword;
    endcase
  end

  assign mem_we = !reset && enter_resp && op_wr && !fault_d;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wword;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      load_data_q  <= '0;
      fault_q      <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        fault_q      <= fault_d;
        load_data_q  <= (fault_d || !op_rd) ? '0 : ld_d;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= store_data;
            cnt_q   <= CNT_INIT;
            state_q <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else cnt_q <= cnt_q - 1'b1;
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table with queued expectations,
// reset-abort sequence and back-to-back streaming at latency 1 and 3.
module tb_load_store_unit;

  localparam int LAT = 2;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    logic        ef, cd;
    logic [31:0] ed;
  } vec_t;

  typedef struct {
    logic        ef, cd;
    logic [31:0] ed;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, store_data = '0;
  logic        req_ready, resp_valid, fault, busy;
  logic [31:0] load_data;

  logic [1:0]  sv = '0;
  logic [1:0]  srdy, sresp, sbusy, sf;
  logic [31:0] sld0, sld1;

  int total = 0;
  int bad = 0;
  vec_t tbl[$];
  exp_t sb[$];

  load_store_unit #(.DEPTH_WORDS(64), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .resp_valid(resp_valid), .load_data(load_data),
    .fault(fault), .busy(busy)
  );

  load_store_unit #(.DEPTH_WORDS(64), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .req_valid(sv[0]), .req_ready(srdy[0]),
    .mem_read(1'b1), .mem_write(1'b0),
    .funct3(3'b010), .addr(32'h0), .store_data(32'h0),
    .resp_valid(sresp[0]), .load_data(sld0),
    .fault(sf[0]), .busy(sbusy[0])
  );

  load_store_unit #(.DEPTH_WORDS(64), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset),
    .req_valid(sv[1]), .req_ready(srdy[1]),
    .mem_read(1'b1), .mem_write(1'b0),
    .funct3(3'b010), .addr(32'h0), .store_data(32'h0),
    .resp_valid(sresp[1]), .load_data(sld1),
    .fault(sf[1]), .busy(sbusy[1])
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cyc %0d)",
               nm, got, exp, cyc);
    end
  endtask

  function automatic vec_t v(input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic ef,
                             input logic cd, input logic [31:0] ed);
    vec_t r;
    r.rd = rd; r.wr = wr; r.f3 = f3; r.a = a; r.wd = wd;
    r.ef = ef; r.cd = cd; r.ed = ed;
    return r;
  endfunction

  task automatic run(input vec_t t);
    exp_t e;
    bit got;
    @(negedge clk);
    chk("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; mem_read = t.rd; mem_write = t.wr;
    funct3 = t.f3; addr = t.a; store_data = t.wd;
    e.ef = t.ef; e.cd = t.cd; e.ed = t.ed; e.n = cyc;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    mem_read = 1'($urandom); mem_write = 1'($urandom);
    funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    if (!got) begin
      chk("resp_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", 32'(cyc - e.n), 32'(LAT));
      chk("fault", fault, e.ef);
      if (e.cd) chk("load_data", load_data, e.ed);
    end
  endtask

  initial begin
    int acc[2], nacc[2], nresp[2];
    bit pend[2], blk[2];

    repeat (2) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    reset = 1'b0;

    tbl.push_back(v(0,1,3'd2,32'd8,32'hdeadbeef,0,0,0));
    tbl.push_back(v(1,0,3'd2,32'd8,32'h0,0,1,32'hdeadbeef));
    tbl.push_back(v(0,1,3'd2,32'd12,32'h11223344,0,0,0));
    tbl.push_back(v(0,1,3'd0,32'd13,32'haaaaaa80,0,0,0));
    tbl.push_back(v(1,0,3'd0,32'd13,32'h0,0,1,32'hffffff80));
    tbl.push_back(v(1,0,3'd4,32'd13,32'h0,0,1,32'h00000080));
    tbl.push_back(v(1,0,3'd2,32'd12,32'h0,0,1,32'h11228044));
    tbl.push_back(v(1,0,3'd1,32'd14,32'h0,0,1,32'h00001122));
    tbl.push_back(v(0,1,3'd2,32'd4,32'h00005555,0,0,0));
    tbl.push_back(v(0,1,3'd1,32'd6,32'h1234beef,0,0,0));
    tbl.push_back(v(1,0,3'd1,32'd6,32'h0,0,1,32'hffffbeef));
    tbl.push_back(v(1,0,3'd5,32'd6,32'h0,0,1,32'h0000beef));
    tbl.push_back(v(1,0,3'd2,32'd4,32'h0,0,1,32'hbeef5555));
    tbl.push_back(v(1,0,3'd2,32'd2,32'h0,1,1,32'h0));
    tbl.push_back(v(0,1,3'd1,32'd5,32'hffffffff,1,1,32'h0));
    tbl.push_back(v(1,0,3'd2,32'd256,32'h0,1,1,32'h0));
    tbl.push_back(v(1,0,3'd3,32'd8,32'h0,1,1,32'h0));
    tbl.push_back(v(1,1,3'd2,32'd8,32'h0,1,1,32'h0));
    tbl.push_back(v(0,1,3'd3,32'd8,32'h0,1,1,32'h0));
    tbl.push_back(v(0,0,3'd2,32'd8,32'h0,1,1,32'h0));
    tbl.push_back(v(1,0,3'd6,32'd8,32'h0,1,1,32'h0));
    tbl.push_back(v(0,1,3'd4,32'd8,32'h0,1,1,32'h0));
    tbl.push_back(v(1,0,3'd2,32'd8,32'h0,0,1,32'hdeadbeef));
    tbl.push_back(v(1,0,3'd2,32'd4,32'h0,0,1,32'hbeef5555));
    tbl.push_back(v(0,1,3'd2,32'd252,32'hcafef00d,0,0,0));
    tbl.push_back(v(1,0,3'd2,32'd252,32'h0,0,1,32'hcafef00d));
    tbl.push_back(v(1,0,3'd0,32'd255,32'h0,0,1,32'hffffffca));
    tbl.push_back(v(1,0,3'd2,32'd253,32'h0,1,1,32'h0));
    tbl.push_back(v(0,1,3'd2,32'd0,32'h5,0,0,0));
    tbl.push_back(v(0,1,3'd2,32'd256,32'h99,1,1,32'h0));
    tbl.push_back(v(1,0,3'd2,32'd0,32'h0,0,1,32'h5));
    foreach (tbl[i]) run(tbl[i]);

    // Store aborted by reset while waiting; request under reset ignored.
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
    funct3 = 3'd2; addr = 32'd0; store_data = 32'h1;
    @(negedge clk);
    chk("abort_busy_wait", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_resp_valid", resp_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", req_ready, 1'b1);
    @(negedge clk);
    chk("rst_req_ignored", busy, 1'b0);
    reset = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_resp", resp_valid, 1'b0);
    end
    run(v(1,0,3'd2,32'd0,32'h0,0,1,32'h5));

    // Streaming with req_valid held high on the latency-1 and -3 units.
    for (int j = 0; j < 2; j++) begin
      acc[j] = 0; nacc[j] = 0; nresp[j] = 0;
      pend[j] = 1'b0; blk[j] = 1'b0;
    end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        int lat;
        bit er;
        lat = (j == 0) ? 1 : 3;
        if (!pend[j] && sv[j] && !blk[j]) begin
          pend[j] = 1'b1;
          acc[j] = cyc;
          nacc[j]++;
        end
        er = pend[j] && (cyc - acc[j] == lat - 1);
        chk($sformatf("stream%0d_resp", lat), sresp[j], er);
        chk($sformatf("stream%0d_busy", lat), sbusy[j], pend[j]);
        chk($sformatf("stream%0d_ready", lat), srdy[j], !pend[j]);
        if (sresp[j]) nresp[j]++;
        blk[j] = er;
        if (er) pend[j] = 1'b0;
        sv[j] = (nacc[j] < 3);
      end
    end
    chk("stream1_count", 32'(nresp[0]), 32'd3);
    chk("stream3_count", 32'(nresp[1]), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
